// File: rtl/dmem_stall_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory stall controller.
// The access timeout is enabled by defining DMEM_TIMEOUT_EN.
package dmem_stall_ctrl_pkg;

  // Legacy state codes, kept so existing debug probes decode unchanged
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    WAIT = S_WAIT,
    DONE = S_DONE
  } dmem_state_e;

  // Load result returned when a read is abandoned by the timeout
  localparam logic [31:0] DMEM_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// Request/acknowledge bus between the stall controller and a multi-cycle data memory.
interface dmem_stall_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory controller: one req/ack transaction per load/store, stalling the pipeline meanwhile.
// Optional WAIT timeout with sticky timeout_o when DMEM_TIMEOUT_EN is defined.
module dmem_stall_ctrl
  import dmem_stall_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef DMEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  dmem_stall_ctrl_if.master    mem_bus,
  output logic [DATA_W-1:0]    rdata_o,
  output logic                 MemStall_o,
  output logic                 timeout_o
);

  dmem_state_e       state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              access_req;

  assign access_req = MemRead_i | MemWrite_i;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             terminal;

  // cnt_q holds the number of WAIT cycles already elapsed before this one
  assign terminal = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (access_req) begin
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
`ifdef DMEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (mem_bus.mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            rdata_d = mem_bus.mem_rdata;
          end
        end
`ifdef DMEM_TIMEOUT_EN
        else if (terminal) begin
          state_d = DONE;
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          if (!we_q) begin
            rdata_d = DATA_W'(DMEM_ERR_RDATA);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Stall is qualified by reset so a held MemRead/MemWrite cannot stall during reset
  assign MemStall_o = rst_n_i & ((state_q == WAIT) | ((state_q == IDLE) & access_req));

  assign mem_bus.mem_req   = req_q;
  assign mem_bus.mem_we    = we_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_wdata = wdata_q;
  assign rdata_o           = rdata_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed self-checking bench for dmem_stall_ctrl; the timeout scenario follows DMEM_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_dmem_stall_ctrl;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] addr   = '0;
  logic [31:0] wdata  = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        tmo;

  int total = 0;
  int bad   = 0;

  int   req_starts = 0;
  logic req_prev   = 1'b0;

  dmem_stall_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_stall_ctrl #(
    .ADDR_W(32),
    .DATA_W(32)
`ifdef DMEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .MemRead_i  (mem_rd),
    .MemWrite_i (mem_wr),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .mem_bus    (bus),
    .rdata_o    (rdata),
    .MemStall_o (stall),
    .timeout_o  (tmo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    req_prev <= bus.mem_req;
    if (bus.mem_req && !req_prev) req_starts <= req_starts + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one access from IDLE; ack arrives in WAIT cycle n_ack. Returns observations only.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input int unsigned n_ack,
                            input logic [31:0] rd_val, output int unsigned stalls,
                            output bit stable, output bit done_ok);
    mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
    stalls = 0; stable = 1'b1;
    @(negedge clk);
    if (stall) stalls++;
    for (int unsigned k = 1; k <= n_ack; k++) begin
      tick();
      if (k == n_ack) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = rd_val;
      end
      @(negedge clk);
      if (stall) stalls++;
      if (!(bus.mem_req === 1'b1 && bus.mem_we === wr && bus.mem_addr === a &&
            (!wr || bus.mem_wdata === d))) stable = 1'b0;
    end
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    if (stall) stalls++;
    done_ok = (stall === 1'b0 && bus.mem_req === 1'b0);
    tick();
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.mem_req); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.mem_we); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.mem_wdata); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", tmo); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int unsigned s; bit st, dn; int r0;
    r0 = req_starts;
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h1234_5678, s, st, dn);
    total++; if (s != 2) begin bad++; $display("FAIL load_stall_cycles got=%0d exp=2", s); end
    total++; if (!st) begin bad++; $display("FAIL load_bus_stable got=0 exp=1"); end
    total++; if (!dn) begin bad++; $display("FAIL load_done_release got=0 exp=1"); end
    total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL load_rdata got=%h exp=12345678", rdata); end
    total++; if (req_starts - r0 != 1) begin bad++; $display("FAIL load_req_count got=%0d exp=1", req_starts - r0); end
    @(negedge clk);
    total++; if (stall !== 1'b0 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL load_idle_after got=stall%b/req%b exp=0/0", stall, bus.mem_req);
    end
    tick();
  endtask

  task automatic test_store();
    int unsigned s; bit st, dn; int r0;
    r0 = req_starts;
    run_access(1'b0, 1'b1, 32'h20, 32'h0000_CAFE, 4, 32'h7777_7777, s, st, dn);
    total++; if (s != 5) begin bad++; $display("FAIL store_stall_cycles got=%0d exp=5", s); end
    total++; if (!st) begin bad++; $display("FAIL store_bus_stable got=0 exp=1"); end
    total++; if (!dn) begin bad++; $display("FAIL store_done_release got=0 exp=1"); end
    total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL store_rdata_kept got=%h exp=12345678", rdata); end
    total++; if (req_starts - r0 != 1) begin bad++; $display("FAIL store_req_count got=%0d exp=1", req_starts - r0); end
  endtask

  task automatic test_back_to_back();
    int unsigned s1, s2; bit st1, st2, d1, d2; int r0;
    r0 = req_starts;
    run_access(1'b1, 1'b0, 32'h0, 32'h0, 1, 32'hAAAA_0000, s1, st1, d1);
    total++; if (rdata !== 32'hAAAA_0000) begin bad++; $display("FAIL b2b_rdata0 got=%h exp=aaaa0000", rdata); end
    run_access(1'b1, 1'b0, 32'h4, 32'h0, 1, 32'h5555_0004, s2, st2, d2);
    total++; if (s1 != 2 || s2 != 2) begin bad++; $display("FAIL b2b_stall_cycles got=%0d,%0d exp=2,2", s1, s2); end
    total++; if (!d1 || !d2 || !st1 || !st2) begin bad++; $display("FAIL b2b_release got=%b%b%b%b exp=1111", d1, d2, st1, st2); end
    total++; if (rdata !== 32'h5555_0004) begin bad++; $display("FAIL b2b_rdata1 got=%h exp=55550004", rdata); end
    total++; if (req_starts - r0 != 2) begin bad++; $display("FAIL b2b_req_count got=%0d exp=2", req_starts - r0); end
  endtask

  task automatic test_read_write_both();
    int unsigned s; bit st, dn;
    run_access(1'b1, 1'b1, 32'h8, 32'h0000_0077, 2, 32'h9999_9999, s, st, dn);
    total++; if (!st) begin bad++; $display("FAIL both_is_write got=0 exp=1"); end
    total++; if (s != 3 || !dn) begin bad++; $display("FAIL both_stall got=%0d/%b exp=3/1", s, dn); end
    total++; if (rdata !== 32'h5555_0004) begin bad++; $display("FAIL both_rdata_kept got=%h exp=55550004", rdata); end
  endtask

  task automatic test_ack_in_idle();
    int r0;
    r0 = req_starts;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    total++; if (stall !== 1'b0 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL idle_ack_state got=stall%b/req%b exp=0/0", stall, bus.mem_req);
    end
    tick();
    bus.mem_ack = 1'b0;
    total++; if (rdata !== 32'h5555_0004) begin bad++; $display("FAIL idle_ack_rdata got=%h exp=55550004", rdata); end
    total++; if (req_starts != r0) begin bad++; $display("FAIL idle_ack_req got=%0d exp=0", req_starts - r0); end
  endtask

  task automatic test_reset_mid_wait();
    int r1;
    mem_rd = 1'b1; addr = 32'h40;
    @(negedge clk);
    tick();
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rst_wait_req got=%b exp=1", bus.mem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL rst_async_drop got=req%b/stall%b exp=0/0", bus.mem_req, stall);
    end
    total++; if (bus.mem_addr !== 32'h0 || rdata !== 32'h0) begin
      bad++; $display("FAIL rst_async_regs got=%h/%h exp=0/0", bus.mem_addr, rdata);
    end
    mem_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r1 = req_starts;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1357_2468;
    @(negedge clk);
    total++; if (stall !== 1'b0 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL late_ack_state got=stall%b/req%b exp=0/0", stall, bus.mem_req);
    end
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL late_ack_rdata got=%h exp=0", rdata); end
    total++; if (req_starts != r1 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL late_ack_req got=%0d/%b exp=0/0", req_starts - r1, bus.mem_req);
    end
    tick();
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned s; bit st, dn; int unsigned waits;
    run_access(1'b1, 1'b0, 32'h300, 32'h0, 8, 32'h0000_2222, s, st, dn);
    total++; if (s != 9 || rdata !== 32'h0000_2222) begin
      bad++; $display("FAIL tmo_ack_wins got=%0d/%h exp=9/00002222", s, rdata);
    end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL tmo_ack_wins_flag got=%b exp=0", tmo); end
    mem_rd = 1'b1; addr = 32'h304;
    @(negedge clk);
    waits = 0;
    for (int unsigned k = 0; k < 40; k++) begin
      tick();
      @(negedge clk);
      if (bus.mem_req === 1'b1) waits++;
      else break;
    end
    total++; if (waits != 8) begin bad++; $display("FAIL tmo_wait_cycles got=%0d exp=8", waits); end
    total++; if (stall !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL tmo_done got=stall%b/%h exp=0/deadbeef", stall, rdata);
    end
    total++; if (tmo !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b exp=1", tmo); end
    tick();
    mem_rd = 1'b0;
    run_access(1'b1, 1'b0, 32'h308, 32'h0, 1, 32'h0000_3333, s, st, dn);
    total++; if (tmo !== 1'b1 || rdata !== 32'h0000_3333) begin
      bad++; $display("FAIL tmo_sticky got=%b/%h exp=1/00003333", tmo, rdata);
    end
  endtask
`else
  task automatic test_timeout();
    bit held;
    mem_rd = 1'b1; addr = 32'h200;
    @(negedge clk);
    held = 1'b1;
    for (int unsigned k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      if (!(stall === 1'b1 && bus.mem_req === 1'b1)) held = 1'b0;
    end
    total++; if (!held) begin bad++; $display("FAIL notmo_wait_held got=0 exp=1"); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL notmo_flag got=%b exp=0", tmo); end
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_1111;
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    total++; if (stall !== 1'b0 || rdata !== 32'h0000_1111) begin
      bad++; $display("FAIL notmo_done got=stall%b/%h exp=0/00001111", stall, rdata);
    end
    tick();
    mem_rd = 1'b0;
  endtask
`endif

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_read_write_both();
    test_ack_in_idle();
    test_reset_mid_wait();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
